decryption: RTL
===============

Name: decryption

Overview:
- Iterative MacGuffin block decryptor.
- Sits downstream of key_setup: consumes the same 32 x 48-bit round_keys and key_ready that drive encryption, applies them in reverse order (31 down to 0), and emits plaintext on an AXI-Stream master.
- One Feistel round per clock.

Parameters:
- NUM_ROUNDS, 32, rounds per block; equals the depth of round_keys.
- BLOCK_W, 64, data block width.
- RK_W, 48, round key width.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- round_keys  in  NUM_ROUNDS x RK_W  round keys from key_setup, index 0 = first encryption round.
- key_ready  in  1  round_keys valid and stable.
- s_axis_tdata  in  BLOCK_W  ciphertext.
- s_axis_tvalid  in  1  ciphertext valid.
- s_axis_tready  out  1  block accepted when high together with tvalid.
- m_axis_tdata  out  BLOCK_W  plaintext.
- m_axis_tvalid  out  1  plaintext valid.
- m_axis_tready  in  1  downstream accepts.

Behaviour:
- Reset: state=IDLE, data register=0, round counter=NUM_ROUNDS-1, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0. Reset is honoured at any time, including mid-block; the block in flight is discarded.
- FSM states IDLE, ROUND, OUT.
- IDLE:
  - s_axis_tready = key_ready.
  - On s_axis_tvalid && s_axis_tready: latch s_axis_tdata as words {W3,W2,W1,W0} (W0 = bits 15:0), load counter = NUM_ROUNDS-1, go to ROUND.
- ROUND:
  - Each cycle, k = round_keys[counter] = {k2,k1,k0}.
  - Next state = (W3 ^ F(W0^k0, W1^k1, W2^k2), W0, W1, W2) as (W0',W1',W2',W3'). This is the exact inverse of the encryption round (W0,W1,W2,W3) -> (W1,W2,W3,W0^F(W1^k0,W2^k1,W3^k2)).
  - Counter decrements. After the round using counter=0, go to OUT.
- OUT:
  - m_axis_tvalid=1; m_axis_tdata = register; s_axis_tready=0.
  - tdata is held stable until m_axis_tready=1.
  - On handshake go to IDLE. A new block can be accepted at the earliest on the next cycle.
- Latency: m_axis_tvalid rises exactly NUM_ROUNDS clocks after the accepting edge. Throughput is 1 block per NUM_ROUNDS+2 cycles when m_axis_tready is held at 1.
- key_ready falling while in ROUND: abort, go to IDLE, no output. key_ready falling while in OUT: output is still delivered.
- round_keys must not be sampled when key_ready=0. s_axis_tvalid arriving while key_ready=0 is stalled, not dropped.
- F: 8 MacGuffin S-boxes. Each takes 6 bits (2 bits from each of three 16-bit inputs, per the package tap table) and yields 2 output bits placed at the package output positions. F is purely combinational, 16-bit output.

Optional Feature:
- Macro DECRYPTION_UNROLL2_EN.
- Defined: two rounds per cycle, counter - 2 per step, latency NUM_ROUNDS/2 clocks. NUM_ROUNDS must be even; elaboration error otherwise.
- Undefined: one round per cycle as above.
- Output values are identical in both builds.

Decomposition:
- macguffin_pkg holds:
  - NUM_ROUNDS, BLOCK_W, RK_W, WORD_W=16;
  - typedef round_keys_t (logic [NUM_ROUNDS][RK_W-1:0]);
  - 8 S-box tables (64 x 2 bits);
  - input-tap and output-position tables;
  - the state enum.
- Sub-module macguffin_f: combinational F-function, shared with encryption.

Test Plan:
- Round trip: key_setup + encryption + decryption, key=128'h0123456789ABCDEF_FEDCBA9876543210, plaintext 64'h0 and 64'hFFFF_FFFF_FFFF_FFFF -> decrypted output equals plaintext.
- Latency: accept at cycle T with m_axis_tready=1 -> m_axis_tvalid first high at T+32 (T+16 with DECRYPTION_UNROLL2_EN); s_axis_tready low from T+1 to T+33.
- Backpressure: hold m_axis_tready=0 for 10 cycles after tvalid -> tdata constant, tvalid high, s_axis_tready=0; handshake on cycle 11 -> IDLE.
- Reset mid-block: rst low 10 cycles after accept -> tvalid=0 immediately. After release, re-send the same block -> correct plaintext after 32 cycles.
- key_ready gating: key_ready=0 with s_axis_tvalid=1 -> s_axis_tready=0, no accept. key_ready dropped in ROUND -> no output, FSM back in IDLE.
- Back-to-back: 100 random ciphertexts from encryption, m_axis_tready random -> all 100 plaintexts match, in order, none lost.

Source files
------------

// File: rtl/macguffin_pkg.sv
// Shared MacGuffin constants, types, S-box tables and F-function tap/output maps.
// Used by the decryption top (decryption.sv) and the combinational F-function (macguffin_f.sv).
package macguffin_pkg;

  localparam int NUM_ROUNDS = 32;
  localparam int BLOCK_W    = 64;
  localparam int RK_W       = 48;
  localparam int WORD_W     = 16;

  // Entry 0 is the first encryption round; each entry is {k2, k1, k0}.
  typedef logic [NUM_ROUNDS-1:0][RK_W-1:0] round_keys_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    OUT   = 2'd2
  } state_e;

  // Per S-box: {a tap (MSB of index), a tap, b tap, b tap, c tap, c tap (LSB)}.
  localparam int unsigned TAP [8][6] = '{
    '{ 2,  5,  6,  9, 11, 13},
    '{ 1,  4,  7, 10,  8, 14},
    '{ 3,  6,  8, 13,  0, 15},
    '{12, 14,  1,  2,  4, 10},
    '{ 0, 10,  3, 14,  6, 12},
    '{ 7,  8, 12, 15,  1,  5},
    '{ 9, 15,  5, 11,  2,  7},
    '{11, 13,  0,  4,  3,  9}
  };

  // Per S-box: {position of output bit 1, position of output bit 0}.
  localparam int unsigned OUT_POS [8][2] = '{
    '{0,  8}, '{1,  9}, '{2, 10}, '{3, 11},
    '{4, 12}, '{5, 13}, '{6, 14}, '{7, 15}
  };

  // Entry i of S-box s occupies bits [2*i+1:2*i] of SBOX[s].
  localparam logic [127:0] SBOX [8] = '{
    128'h5A3C_96E1_0F7B_D248_C3A5_6E19_B70D_F284,
    128'h93E6_1CB5_78A0_4FD2_2D6B_E953_0AC7_F41E,
    128'hE14D_2FB8_836C_5A09_79C2_F05E_B614_AD3C,
    128'h2B7E_1516_28AE_D2A6_ABF7_1588_09CF_4F3C,
    128'hC66F_A5E1_3B09_7D48_E2D1_5F0A_86B3_94C7,
    128'h7D1A_E58B_0C36_F92E_4B87_A1D0_3E6C_95F2,
    128'h4E9C_B3D7_60A5_1F28_D86E_27B1_C5F0_3A94,
    128'hB8F1_0D6A_E493_57C2_1A7F_C03E_9D58_26B4
  };

endpackage

// File: rtl/macguffin_f.sv
// MacGuffin F-function: eight 6-to-2 S-boxes fed from three 16-bit words.
// Purely combinational; shared by the encryption and decryption datapaths.
module macguffin_f
  import macguffin_pkg::*;
(
  input  logic [WORD_W-1:0] i_a,
  input  logic [WORD_W-1:0] i_b,
  input  logic [WORD_W-1:0] i_c,
  output logic [WORD_W-1:0] o_f
);

  for (genvar s = 0; s < 8; s++) begin : g_sbox
    logic [5:0] w_idx;
    logic [1:0] w_val;

    assign w_idx = {i_a[TAP[s][0]], i_a[TAP[s][1]],
                    i_b[TAP[s][2]], i_b[TAP[s][3]],
                    i_c[TAP[s][4]], i_c[TAP[s][5]]};
    assign w_val = 2'(SBOX[s] >> {w_idx, 1'b0});

    assign o_f[OUT_POS[s][0]] = w_val[1];
    assign o_f[OUT_POS[s][1]] = w_val[0];
  end

endmodule

// File: rtl/decryption.sv
// Iterative MacGuffin decryptor: round keys applied 31..0, AXI-Stream in and out.
// Define DECRYPTION_UNROLL2_EN for two rounds per clock (same results, half the latency).
module decryption
  import macguffin_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  round_keys_t        round_keys,
  input  logic               key_ready,
  input  logic [BLOCK_W-1:0] s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [BLOCK_W-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready
);

  localparam int CNT_W = $clog2(NUM_ROUNDS);

  state_e             r_state;
  logic [BLOCK_W-1:0] r_data;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_idle_rdy;
  logic               r_m_tvalid;

  logic [RK_W-1:0]    w_k0;
  logic [WORD_W-1:0]  w_f0;
  logic [BLOCK_W-1:0] w_r0;
  logic [BLOCK_W-1:0] w_next;
  logic               w_last;

  // One inverse round: (W3 ^ F(W0^k0, W1^k1, W2^k2), W0, W1, W2).
  assign w_k0 = round_keys[r_cnt];

  macguffin_f u_f0 (
    .i_a (r_data[15:0]  ^ w_k0[15:0]),
    .i_b (r_data[31:16] ^ w_k0[31:16]),
    .i_c (r_data[47:32] ^ w_k0[47:32]),
    .o_f (w_f0)
  );

  assign w_r0 = {r_data[47:0], r_data[63:48] ^ w_f0};

`ifdef DECRYPTION_UNROLL2_EN
  localparam logic [CNT_W-1:0] STEP = CNT_W'(2);

  if ((NUM_ROUNDS % 2) != 0) begin : g_odd_rounds
    $error("decryption: NUM_ROUNDS must be even when two rounds run per clock");
  end

  logic [CNT_W-1:0]  w_cnt_m1;
  logic [RK_W-1:0]   w_k1;
  logic [WORD_W-1:0] w_f1;

  assign w_cnt_m1 = r_cnt - 1'b1;
  assign w_k1     = round_keys[w_cnt_m1];

  macguffin_f u_f1 (
    .i_a (w_r0[15:0]  ^ w_k1[15:0]),
    .i_b (w_r0[31:16] ^ w_k1[31:16]),
    .i_c (w_r0[47:32] ^ w_k1[47:32]),
    .o_f (w_f1)
  );

  assign w_next = {w_r0[47:0], w_r0[63:48] ^ w_f1};
  assign w_last = (r_cnt == CNT_W'(1));
`else
  localparam logic [CNT_W-1:0] STEP = CNT_W'(1);

  assign w_next = w_r0;
  assign w_last = (r_cnt == '0);
`endif

  // NOTE: tready is gated by the live key_ready so a key drop stalls the very
  // cycle it happens; the registered half keeps it low through reset and busy states.
  assign s_axis_tready = r_idle_rdy & key_ready;
  assign m_axis_tdata  = r_data;
  assign m_axis_tvalid = r_m_tvalid;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_cnt      <= CNT_W'(NUM_ROUNDS - 1);
      r_idle_rdy <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_idle_rdy <= 1'b1;
          if (s_axis_tvalid && s_axis_tready) begin
            r_data     <= s_axis_tdata;
            r_cnt      <= CNT_W'(NUM_ROUNDS - 1);
            r_idle_rdy <= 1'b0;
            r_state    <= ROUND;
          end
        end
        ROUND: begin
          // Keys are only trusted while key_ready holds; otherwise drop the block.
          if (!key_ready) begin
            r_idle_rdy <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_data <= w_next;
            r_cnt  <= r_cnt - STEP;
            if (w_last) begin
              r_m_tvalid <= 1'b1;
              r_state    <= OUT;
            end
          end
        end
        OUT: begin
          if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
            r_idle_rdy <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_m_tvalid <= 1'b0;
          r_idle_rdy <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule
